// File: rtl/custom_bus_slave_fifo.sv
// custom_bus_slave_fifo: request/ack bus slave; bus writes fill an RX FIFO, bus reads drain a TX FIFO.
module custom_bus_slave_fifo #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m_req,
    input  logic                          m_r0_w1,
    input  logic [DATA_W-1:0]             m_wr_data,
    output logic [DATA_W-1:0]             m_rd_data,
    input  logic                          m_done,
    output logic                          s_ack,
    output logic                          s_data_ack,
    output logic                          rx_valid,
    output logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_ready,
    input  logic                          tx_valid,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          tx_ready,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic [$clog2(TX_DEPTH):0]     tx_count,
    output logic                          busy,
    output logic                          protocol_err
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int TCW = TAW + 1;
    localparam logic [RAW:0] RX_FULL = RX_DEPTH[RAW:0];
    localparam logic [TAW:0] TX_FULL = TX_DEPTH[TAW:0];

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_ACK, WR_DATA, WR_DACK, RD_WAIT, RD_ACK, DONE_WAIT
    } state_t;

    state_t state, next;
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [TAW-1:0] tx_wr, tx_rd;
    logic rx_push, rx_pop, tx_push, tx_pop;

    assign rx_valid = rx_count != '0;
    assign tx_ready = tx_count != TX_FULL;
    assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;
    assign rx_push  = state == WR_DATA;
    assign rx_pop   = rx_ready && rx_valid;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = state == RD_ACK;

    always_comb begin
        next       = state;
        s_ack      = state == WR_ACK || state == RD_ACK;
        s_data_ack = state == WR_DACK;
        m_rd_data  = state == RD_ACK ? tx_mem[tx_rd] : '0;
        busy       = state != IDLE;
        case (state)
            IDLE:      if (m_req) next = m_r0_w1 ? (rx_count < RX_FULL ? WR_ACK : WR_WAIT)
                                             : (tx_count != '0 ? RD_ACK : RD_WAIT);
            WR_WAIT:   if (rx_count < RX_FULL) next = WR_ACK;
            WR_ACK:    next = WR_DATA;
            WR_DATA:   next = WR_DACK;
            WR_DACK:   next = DONE_WAIT;
            RD_WAIT:   if (tx_count != '0) next = RD_ACK;
            RD_ACK:    next = DONE_WAIT;
            DONE_WAIT: if (m_done) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // Only the bus pushes RX, so a slot seen free in WR_WAIT/IDLE is still free at WR_DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            protocol_err <= 1'b0;
            rx_wr        <= '0;
            rx_rd        <= '0;
            tx_wr        <= '0;
            tx_rd        <= '0;
            rx_count     <= '0;
            tx_count     <= '0;
        end else begin
            state        <= next;
            protocol_err <= m_req && state != IDLE;
            if (rx_push) begin
                rx_mem[rx_wr] <= m_wr_data;
                rx_wr         <= rx_wr + RAW'(1);
            end
            if (rx_pop) rx_rd <= rx_rd + RAW'(1);
            if (tx_push) begin
                tx_mem[tx_wr] <= tx_data;
                tx_wr         <= tx_wr + TAW'(1);
            end
            if (tx_pop) tx_rd <= tx_rd + TAW'(1);
            rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
            tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
        end
    end
endmodule

// File: tb/tb_custom_bus_slave_fifo.sv
// tb_custom_bus_slave_fifo: vector table of bus/local operations plus hand-written corner sequences, data checked via queues.
module tb_custom_bus_slave_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_req = 1'b0, m_r0_w1 = 1'b0, m_done = 1'b0;
    logic [7:0] m_wr_data = '0, m_rd_data, rx_data, tx_data = '0;
    logic s_ack, s_data_ack, rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready, busy, protocol_err;
    logic [2:0] rx_count, tx_count;
    int total = 0;
    int bad = 0;
    int lat;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    typedef enum {BWR, BRD, LPUSH, LPOP} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] d;
        int         rxc;
        int         txc;
    } vec_t;
    localparam int NV = 15;
    vec_t vec[NV];

    custom_bus_slave_fifo dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_r0_w1(m_r0_w1), .m_wr_data(m_wr_data),
        .m_rd_data(m_rd_data), .m_done(m_done), .s_ack(s_ack), .s_data_ack(s_data_ack),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_count(rx_count), .tx_count(tx_count),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic req(input logic w);
        m_req = 1'b1;
        m_r0_w1 = w;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            m_req = 1'b0;
            n++;
        end while (!s_ack && n < 40);
        chk("ack_seen", s_ack, 1);
    endtask

    task automatic write_tail(input logic [7:0] d);
        tick();
        m_wr_data = d;
        chk("wr_ack_pulse", s_ack, 0);
        tick();
        chk("wr_dack", s_data_ack, 1);
        rx_q.push_back(d);
        chk("wr_rx_count", rx_count, rx_q.size());
        tick();
        chk("wr_dack_pulse", s_data_ack, 0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("wr_idle", busy, 0);
    endtask

    task automatic read_tail();
        logic [7:0] e;
        if (tx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_model_empty got=read want=no_read");
        end else begin
            e = tx_q.pop_front();
            chk("rd_data", m_rd_data, e);
        end
        tick();
        chk("rd_ack_pulse", s_ack, 0);
        chk("rd_data_zero", m_rd_data, 0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("rd_idle", busy, 0);
    endtask

    task automatic tx_push(input logic [7:0] d);
        chk("tx_ready", tx_ready, tx_q.size() < 4);
        tx_valid = 1'b1;
        tx_data = d;
        if (tx_q.size() < 4) tx_q.push_back(d);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop();
        logic [7:0] e;
        chk("rx_valid", rx_valid, 1);
        if (rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_model_empty got=pop want=no_pop");
        end else begin
            e = rx_q.pop_front();
            chk("rx_data", rx_data, e);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        vec[0]  = '{BWR,   8'hA5, 1, 0};
        vec[1]  = '{LPOP,  8'h00, 0, 0};
        vec[2]  = '{LPUSH, 8'h10, 0, 1};
        vec[3]  = '{LPUSH, 8'h11, 0, 2};
        vec[4]  = '{LPUSH, 8'h12, 0, 3};
        vec[5]  = '{LPUSH, 8'h13, 0, 4};
        vec[6]  = '{LPUSH, 8'h99, 0, 4};
        vec[7]  = '{BRD,   8'h00, 0, 3};
        vec[8]  = '{BRD,   8'h00, 0, 2};
        vec[9]  = '{BRD,   8'h00, 0, 1};
        vec[10] = '{BRD,   8'h00, 0, 0};
        vec[11] = '{BWR,   8'h5A, 1, 0};
        vec[12] = '{BWR,   8'h6B, 2, 0};
        vec[13] = '{LPOP,  8'h00, 1, 0};
        vec[14] = '{LPOP,  8'h00, 0, 0};

        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_s_ack", s_ack, 0);
        chk("rst_s_data_ack", s_data_ack, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_rd_data", m_rd_data, 0);

        for (int i = 0; i < NV; i++) begin
            case (vec[i].op)
                BWR: begin
                    req(1'b1);
                    wait_ack(lat);
                    chk($sformatf("vec%0d_wr_lat", i), lat, 1);
                    write_tail(vec[i].d);
                end
                BRD: begin
                    req(1'b0);
                    wait_ack(lat);
                    chk($sformatf("vec%0d_rd_lat", i), lat, 1);
                    read_tail();
                end
                LPUSH: tx_push(vec[i].d);
                default: rx_pop();
            endcase
            chk($sformatf("vec%0d_rx_count", i), rx_count, vec[i].rxc);
            chk($sformatf("vec%0d_tx_count", i), tx_count, vec[i].txc);
        end

        for (int i = 1; i <= 4; i++) begin
            req(1'b1);
            wait_ack(lat);
            write_tail(8'(i));
        end
        chk("full_rx_count", rx_count, 4);
        req(1'b1);
        tick();
        m_req = 1'b0;
        chk("full_no_ack", s_ack, 0);
        chk("full_busy", busy, 1);
        repeat (2) tick();
        chk("full_still_no_ack", s_ack, 0);
        rx_pop();
        wait_ack(lat);
        chk("full_release_lat", lat, 1);
        write_tail(8'h05);
        repeat (4) rx_pop();
        chk("drain_rx_valid", rx_valid, 0);
        chk("drain_rx_data", rx_data, 0);

        req(1'b0);
        tick();
        m_req = 1'b0;
        chk("rd_empty_no_ack", s_ack, 0);
        repeat (2) tick();
        chk("rd_empty_still_no_ack", s_ack, 0);
        chk("rd_empty_busy", busy, 1);
        tx_push(8'h3C);
        chk("rd_empty_tx_count", tx_count, 1);
        wait_ack(lat);
        chk("rd_empty_lat", lat, 1);
        read_tail();
        chk("rd_empty_tx_count_end", tx_count, 0);

        tx_push(8'h21);
        tx_push(8'h22);
        req(1'b0);
        wait_ack(lat);
        chk("simul_rd_data", m_rd_data, tx_q.pop_front());
        tx_valid = 1'b1;
        tx_data = 8'h23;
        tx_q.push_back(8'h23);
        tick();
        tx_valid = 1'b0;
        chk("simul_tx_count", tx_count, 2);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        repeat (2) begin
            req(1'b0);
            wait_ack(lat);
            read_tail();
        end
        chk("simul_tx_count_end", tx_count, 0);

        req(1'b1);
        wait_ack(lat);
        tick();
        m_wr_data = 8'h77;
        tick();
        rx_q.push_back(8'h77);
        tick();
        chk("perr_in_done_wait", busy, 1);
        m_req = 1'b1;
        tick();
        m_req = 1'b0;
        chk("perr_pulse", protocol_err, 1);
        chk("perr_state_kept", busy, 1);
        chk("perr_no_ack", s_ack, 0);
        tick();
        chk("perr_one_cycle", protocol_err, 0);
        chk("perr_still_done_wait", busy, 1);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("perr_idle", busy, 0);
        chk("perr_rx_count", rx_count, 1);

        req(1'b1);
        wait_ack(lat);
        tick();
        m_wr_data = 8'h88;
        tick();
        chk("rst_mid_dack", s_data_ack, 1);
        chk("rst_mid_rx_count2", rx_count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        tx_q.delete();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_count", rx_count, 0);
        chk("rst_mid_s_data_ack", s_data_ack, 0);
        chk("rst_mid_rx_valid", rx_valid, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/custom_bus_slave_fifo.md
Name: custom_bus_slave_fifo

Overview:
- Slave endpoint of the custom request/ack bus; consumes the bus master's handshakes directly.
- Bus writes push bytes into an RX FIFO, which a local consumer drains.
- Bus reads pop bytes from a TX FIFO, which a local producer fills.
- Applies backpressure by withholding s_ack while the RX FIFO is full (write) or the TX FIFO is empty (read).

Parameters:
DATA_W, 8, bus/FIFO data width.
RX_DEPTH, 4, RX FIFO entries; power of two, >=2.
TX_DEPTH, 4, TX FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
m_req  in  1  master request, one-cycle pulse
m_r0_w1  in  1  sampled with m_req: 0 read, 1 write
m_wr_data  in  DATA_W  write data, valid only in the cycle after s_ack
m_rd_data  out  DATA_W  read data, valid while s_ack=1 in a read, else 0
m_done  in  1  master completion pulse
s_ack  out  1  request acknowledge
s_data_ack  out  1  write-data acknowledge
rx_valid  out  1  RX FIFO not empty
rx_data  out  DATA_W  RX FIFO head (first-word fall-through), 0 when empty
rx_ready  in  1  pop RX when rx_valid
tx_valid  in  1  push tx_data into TX when tx_ready
tx_data  in  DATA_W  local read data
tx_ready  out  1  TX FIFO not full
rx_count  out  clog2(RX_DEPTH)+1  RX occupancy
tx_count  out  clog2(TX_DEPTH)+1  TX occupancy
busy  out  1  FSM not in IDLE
protocol_err  out  1  one-cycle pulse, m_req seen outside IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM=IDLE and both FIFOs empty. s_ack=0, s_data_ack=0, m_rd_data=0, rx_valid=0, rx_data=0, tx_ready=1, counts=0, busy=0, protocol_err=0.
- Output decoding: all bus outputs are Moore-decoded from state, with no combinational path from inputs.
- States: IDLE, WR_WAIT, WR_ACK, WR_DATA, WR_DACK, RD_WAIT, RD_ACK, DONE_WAIT.
- IDLE:
  - m_req&m_r0_w1: go to WR_ACK if rx_count<RX_DEPTH, else WR_WAIT.
  - m_req&!m_r0_w1: go to RD_ACK if tx_count>0, else RD_WAIT.
- WR_WAIT: go to WR_ACK when rx_count<RX_DEPTH. Only the bus pushes RX, so the slot stays reserved.
- WR_ACK: s_ack=1 for exactly one cycle, then WR_DATA.
- WR_DATA: m_wr_data is sampled at the edge leaving this state and pushed into RX. Next state WR_DACK.
- WR_DACK: s_data_ack=1 for exactly one cycle, then DONE_WAIT.
- RD_WAIT: go to RD_ACK when tx_count>0.
- RD_ACK: s_ack=1 and m_rd_data=TX head for one cycle. TX pops at the exiting edge. Next state DONE_WAIT.
- DONE_WAIT: wait for m_done=1, then IDLE.
- Nominal write timing: with m_req in cycle 0, s_ack is in cycle 1, data is sampled in cycle 2, s_data_ack is in cycle 3, and m_done is expected in cycle 4. The slave is back in IDLE in cycle 5.
- Nominal read timing: with m_req in cycle 0, s_ack plus data are in cycle 1, and m_done is expected in cycle 2. The slave is back in IDLE in cycle 3.
- protocol_err: m_req=1 in any state other than IDLE pulses protocol_err in the next cycle. The request is ignored and the state is unchanged.
- FIFO rules:
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - count = pushes minus pops, saturating never needed.
  - A simultaneous push and pop on the same FIFO in one cycle leaves the count unchanged. This is legal even when full or empty only if the pop side is valid.
  - A TX push when tx_ready=0 is dropped. An RX pop when rx_valid=0 is ignored.
  - A local pop/push in the same cycle as a bus push/pop on the same FIFO is handled as simultaneous.
- Byte ordering: strict FIFO order; no reordering or data duplication.
- Reset mid-transaction: immediate return to IDLE with FIFOs flushed, and all handshake outputs low in the following cycle.

Test Plan:
- Reset then idle 5 cycles -> s_ack=s_data_ack=0, rx_valid=0, tx_ready=1, rx_count=tx_count=0, protocol_err=0.
- Bus write 0xA5 -> s_ack high in cycle 1 only, s_data_ack in cycle 3 only, rx_valid=1 with rx_data=0xA5 and rx_count=1 from cycle 3. A pop with rx_ready -> rx_valid=0.
- Five bus writes 0x01..0x05 with rx_ready=0 -> the first four complete, and the fifth holds s_ack=0 (busy=1). Pulse rx_ready once -> the fifth gets s_ack the next cycle. A subsequent drain yields 0x02,0x03,0x04,0x05.
- Bus read with TX empty -> s_ack stays 0. Push tx_data=0x3C -> s_ack=1 with m_rd_data=0x3C exactly one cycle later, and tx_count returns to 0.
- Fill TX (0x10..0x13) -> tx_ready=0; an extra push of 0x99 is dropped. Four bus reads -> return 0x10..0x13 in order, and 0x99 never appears. A bus read pop and a local push in the same cycle -> tx_count unchanged.
- Assert m_req while in DONE_WAIT -> protocol_err pulses once, and the state is unchanged. Assert rst in WR_DACK with rx_count=2 -> next cycle IDLE, rx_count=0, s_data_ack=0.
